regex_stream_counter: RTL and testbench
=======================================

// Module: regex_stream_counter
// PURPOSE
//  Parametrised per-stream regex match counter for the DPI pipeline.
//  - Wraps one external regex engine. Saves and restores the engine's state per stream id.
//  - Counts accepts speculatively within a packet, then commits or discards them at end of packet (eop).
//  - Keeps a global match total and per-stream match totals, with saturation and a registered read port.
// PARAMETERS
//  NUM_STREAMS  64  number of stream contexts; SID_W = $clog2(NUM_STREAMS)
//  STATE_W      8   regex engine state width
//  COUNT_W      16  width of total and per-stream counters (saturating)
//  SPEC_W       12  width of the speculative in-packet counter (saturating)
// PORTS
//  clk            in   1        clock
//  rst_n          in   1        synchronous, active-low reset
//  stream_id      in   SID_W    stream for load/reset/eop
//  load_state     in   1        restore the saved state of stream_id into the engine
//  reset_state    in   1        start stream_id from state 0
//  eop            in   1        end of packet for stream_id
//  enable         in   1        sampled with eop: 1 commits, 0 discards
//  clear_counts   in   1        zero total and all per-stream counters
//  rd_sid         in   SID_W    per-stream count read address
//  eng_state_out  in   STATE_W  engine current state
//  eng_accept     in   1        engine accept pulse, one per match
//  eng_state_in   out  STATE_W  state to load into the engine
//  eng_state_vld  out  1        engine state-load strobe
//  total_count    out  COUNT_W  committed matches over all streams
//  total_sat      out  1        sticky: total_count has saturated
//  rd_count       out  COUNT_W  per-stream count of rd_sid, 1-cycle latency
// BEHAVIOUR
//  Reset values:
//   - All outputs 0; spec count 0; all stream valid bits 0.
//   - RAM contents are not reset. A load of an invalid stream yields state 0.
//  Engine load:
//   - load_state or reset_state at cycle N gives eng_state_vld=1 for exactly cycle N+1.
//   - Load data: eng_state_in = valid ? ram[sid] : 0.
//   - Reset data: eng_state_in = 0.
//   - reset_state wins if both are asserted. Either one also clears spec at N+1.
//  Speculative count: eng_accept increments spec every cycle it is high; spec saturates at 2^SPEC_W-1.
//  eop with enable=1 (commit):
//   - total    += zero-extended spec + eng_accept (same-cycle accept is included).
//   - pcount[sid] += the same amount.
//   - ram[sid] <= eng_state_out; valid[sid] <= 1.
//   - spec cleared next cycle.
//  eop with enable=0 (discard): spec cleared; RAM, valid bits and counters untouched.
//  Saturation:
//   - Counter additions clamp at 2^COUNT_W-1 and never wrap.
//   - total_sat sets on clamp and clears only on rst_n or clear_counts.
//  Simultaneous events:
//   - eop plus load_state, same sid: load returns the state being committed (write-through bypass).
//   - eop plus reset_state: the commit completes first, then the engine is loaded with 0.
//   - clear_counts plus commit: the clear wins; that commit is lost.
//  Read port: rd_count = pcount[rd_sid] registered. A same-cycle commit to rd_sid shows its pre-commit value.
//  Reset mid-packet: spec and valid bits drop. The packet is lost; its matches are never committed.
// STRUCTURE
//  Shared package dpi_pkg:
//   - SID_W function; default STATE_W/COUNT_W constants.
//   - sat_add function.
//  Sub-module stream_ctx_ram:
//   - NUM_STREAMS x (STATE_W + COUNT_W) sync-write RAM.
//   - Two read ports: ctx restore, and rd_sid.
//   - Valid bitmap in flops.
//  Top level holds the load strobe pipeline, the spec counter, the total counter and the bypass mux.
// TESTING
//  1. reset_state sid 3; 5 accepts; eop enable=1 -> total=5, pcount[3]=5, ram[3]=engine state.
//  2. load_state sid 3 -> eng_state_vld at N+1 with saved state. load_state sid 9 (never written) -> state 0.
//  3. 4 accepts; eop enable=0 -> total unchanged; spec=0; next commit counts only new accepts.
//  4. COUNT_W=4; commit 10, then 10 -> total=15, total_sat=1. clear_counts -> 0, sat=0.
//  5. accept on the eop cycle after 2 prior accepts -> commit adds 3. eop plus load_state same sid -> bypass state loaded.
//  6. rst_n low mid-packet after 3 accepts -> all outputs 0; a later load of that sid returns 0.

Source files
------------

// File: rtl/dpi_pkg.sv
// Shared DPI pipeline helpers: stream-id width derivation and saturating counter arithmetic.
package dpi_pkg;

  localparam int unsigned STATE_W_DEF = 8;
  localparam int unsigned COUNT_W_DEF = 16;

  function automatic int unsigned sid_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Operands are carried in 64 bits so the raw sum never wraps for counters up to 32 bits.
  function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b,
                                          input int unsigned w);
    logic [63:0] max_v;
    logic [63:0] sum;
    max_v = (64'd1 << w) - 64'd1;
    sum   = a + b;
    return (sum > max_v) ? max_v : sum;
  endfunction

  function automatic logic sat_hit(input logic [63:0] a, input logic [63:0] b,
                                   input int unsigned w);
    return (a + b) > ((64'd1 << w) - 64'd1);
  endfunction

endpackage

// File: rtl/stream_ctx_ram.sv
// Per-stream context store: saved engine state plus committed match count, with valid bitmaps
// so that reset and clear_counts take effect in one cycle without touching the array.
module stream_ctx_ram
  import dpi_pkg::*;
#(
  parameter int unsigned NUM_STREAMS = 64,
  parameter int unsigned STATE_W     = STATE_W_DEF,
  parameter int unsigned COUNT_W     = COUNT_W_DEF,
  localparam int unsigned SID_W      = sid_w(NUM_STREAMS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en,
  input  logic [SID_W-1:0]   wr_sid,
  input  logic [STATE_W-1:0] wr_state,
  input  logic [COUNT_W-1:0] wr_count,
  input  logic               clr_counts,
  input  logic [SID_W-1:0]   ctx_sid,
  output logic [STATE_W-1:0] ctx_state,
  output logic [COUNT_W-1:0] ctx_count,
  input  logic [SID_W-1:0]   rd_sid,
  output logic [COUNT_W-1:0] rd_count
);

  localparam int unsigned WORD_W = STATE_W + COUNT_W;

  logic [WORD_W-1:0]      mem [NUM_STREAMS];
  logic [NUM_STREAMS-1:0] st_vld_q;
  logic [NUM_STREAMS-1:0] cnt_vld_q;
  logic [WORD_W-1:0]      ctx_word;
  logic [WORD_W-1:0]      rd_word;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_sid] <= {wr_state, wr_count};
    end
  end

  // A clear only drops the count-valid bits; saved engine states stay usable.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_vld_q  <= '0;
      cnt_vld_q <= '0;
    end else begin
      if (wr_en) begin
        st_vld_q[wr_sid] <= 1'b1;
      end
      if (clr_counts) begin
        cnt_vld_q <= '0;
      end else if (wr_en) begin
        cnt_vld_q[wr_sid] <= 1'b1;
      end
    end
  end

  always_comb begin
    ctx_word  = mem[ctx_sid];
    rd_word   = mem[rd_sid];
    ctx_state = st_vld_q[ctx_sid] ? ctx_word[WORD_W-1:COUNT_W] : '0;
    ctx_count = cnt_vld_q[ctx_sid] ? ctx_word[COUNT_W-1:0] : '0;
    rd_count  = cnt_vld_q[rd_sid] ? rd_word[COUNT_W-1:0] : '0;
  end

endmodule

// File: rtl/regex_stream_counter.sv
// Per-stream regex match counter: saves/restores engine state per stream, counts accepts
// speculatively within a packet and commits or discards them at end of packet.
module regex_stream_counter
  import dpi_pkg::*;
#(
  parameter int unsigned NUM_STREAMS = 64,
  parameter int unsigned STATE_W     = STATE_W_DEF,
  parameter int unsigned COUNT_W     = COUNT_W_DEF,
  parameter int unsigned SPEC_W      = 12,
  localparam int unsigned SID_W      = sid_w(NUM_STREAMS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [SID_W-1:0]   stream_id,
  input  logic               load_state,
  input  logic               reset_state,
  input  logic               eop,
  input  logic               enable,
  input  logic               clear_counts,
  input  logic [SID_W-1:0]   rd_sid,
  input  logic [STATE_W-1:0] eng_state_out,
  input  logic               eng_accept,
  output logic [STATE_W-1:0] eng_state_in,
  output logic               eng_state_vld,
  output logic [COUNT_W-1:0] total_count,
  output logic               total_sat,
  output logic [COUNT_W-1:0] rd_count
);

  logic               commit;
  logic [63:0]        add_amt;
  logic [SPEC_W-1:0]  spec_q, spec_d;
  logic [COUNT_W-1:0] total_q, total_d;
  logic               total_sat_q, total_sat_d;
  logic               ld_vld_q, ld_vld_d;
  logic [STATE_W-1:0] ld_state_q, ld_state_d;
  logic [COUNT_W-1:0] rd_count_q;
  logic [STATE_W-1:0] ctx_state;
  logic [COUNT_W-1:0] ctx_count;
  logic [COUNT_W-1:0] ctx_count_new;
  logic [COUNT_W-1:0] rd_count_raw;

  assign commit        = eop & enable;
  // An accept on the eop cycle belongs to the packet being committed.
  assign add_amt       = 64'(spec_q) + 64'(eng_accept);
  assign ctx_count_new = COUNT_W'(sat_add(64'(ctx_count), add_amt, COUNT_W));

  stream_ctx_ram #(
    .NUM_STREAMS (NUM_STREAMS),
    .STATE_W     (STATE_W),
    .COUNT_W     (COUNT_W)
  ) u_ctx_ram (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (commit),
    .wr_sid     (stream_id),
    .wr_state   (eng_state_out),
    .wr_count   (ctx_count_new),
    .clr_counts (clear_counts),
    .ctx_sid    (stream_id),
    .ctx_state  (ctx_state),
    .ctx_count  (ctx_count),
    .rd_sid     (rd_sid),
    .rd_count   (rd_count_raw)
  );

  always_comb begin
    spec_d = spec_q;
    if (load_state || reset_state || eop) begin
      spec_d = '0;
    end else if (eng_accept && (spec_q != '1)) begin
      spec_d = spec_q + SPEC_W'(1'b1);
    end
  end

  // clear_counts beats a same-cycle commit: that packet's matches are dropped.
  always_comb begin
    total_d     = total_q;
    total_sat_d = total_sat_q;
    if (clear_counts) begin
      total_d     = '0;
      total_sat_d = 1'b0;
    end else if (commit) begin
      total_d = COUNT_W'(sat_add(64'(total_q), add_amt, COUNT_W));
      if (sat_hit(64'(total_q), add_amt, COUNT_W)) begin
        total_sat_d = 1'b1;
      end
    end
  end

  // A commit in the same cycle bypasses the RAM so the load sees the state being saved.
  always_comb begin
    ld_vld_d   = load_state | reset_state;
    ld_state_d = ld_state_q;
    if (reset_state) begin
      ld_state_d = '0;
    end else if (load_state) begin
      ld_state_d = commit ? eng_state_out : ctx_state;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      spec_q      <= '0;
      total_q     <= '0;
      total_sat_q <= 1'b0;
      ld_vld_q    <= 1'b0;
      ld_state_q  <= '0;
      rd_count_q  <= '0;
    end else begin
      spec_q      <= spec_d;
      total_q     <= total_d;
      total_sat_q <= total_sat_d;
      ld_vld_q    <= ld_vld_d;
      ld_state_q  <= ld_state_d;
      rd_count_q  <= rd_count_raw;
    end
  end

  assign eng_state_in  = ld_state_q;
  assign eng_state_vld = ld_vld_q;
  assign total_count   = total_q;
  assign total_sat     = total_sat_q;
  assign rd_count      = rd_count_q;

endmodule

// File: tb/tb_regex_stream_counter.sv
// Scoreboard bench: the driver runs a per-packet reference model and queues expected outputs;
// a monitor pops and compares them after every clock edge.
module tb_regex_stream_counter;

  localparam int unsigned NS = 16;
  localparam int unsigned SW = 8;
  localparam int unsigned CW = 6;
  localparam int unsigned PW = 4;
  localparam int CMAX = (1 << CW) - 1;
  localparam int PMAX = (1 << PW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [3:0]    stream_id = '0;
  logic          load_state = 1'b0;
  logic          reset_state = 1'b0;
  logic          eop = 1'b0;
  logic          enable = 1'b0;
  logic          clear_counts = 1'b0;
  logic [3:0]    rd_sid = '0;
  logic [SW-1:0] eng_state_out = '0;
  logic          eng_accept = 1'b0;
  logic [SW-1:0] eng_state_in;
  logic          eng_state_vld;
  logic [CW-1:0] total_count;
  logic          total_sat;
  logic [CW-1:0] rd_count;

  always #5 clk = ~clk;

  regex_stream_counter #(
    .NUM_STREAMS (NS),
    .STATE_W     (SW),
    .COUNT_W     (CW),
    .SPEC_W      (PW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stream_id     (stream_id),
    .load_state    (load_state),
    .reset_state   (reset_state),
    .eop           (eop),
    .enable        (enable),
    .clear_counts  (clear_counts),
    .rd_sid        (rd_sid),
    .eng_state_out (eng_state_out),
    .eng_accept    (eng_accept),
    .eng_state_in  (eng_state_in),
    .eng_state_vld (eng_state_vld),
    .total_count   (total_count),
    .total_sat     (total_sat),
    .rd_count      (rd_count)
  );

  typedef struct {
    bit vld;
    bit chk_st;
    int st;
    int total;
    bit sat;
    int rd;
  } exp_t;

  exp_t exp_q[$];
  int   ld_q[$];
  int   checks = 0;
  int   failures = 0;

  // Reference model: what each stream has saved and committed so far.
  int m_state[NS];
  bit m_svld[NS];
  int m_pcnt[NS];
  int m_total = 0;
  bit m_sat = 0;
  int m_spec = 0;

  // Next-cycle stimulus; pulse fields auto-clear after each tick.
  bit s_rst, s_ld, s_rs, s_e, s_en, s_clr, s_acc;
  int s_sid, s_rsid;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic tick();
    exp_t x;
    int   amt;
    @(negedge clk);
    rst_n         = !s_rst;
    stream_id     = 4'(s_sid);
    load_state    = s_ld;
    reset_state   = s_rs;
    eop           = s_e;
    enable        = s_en;
    clear_counts  = s_clr;
    rd_sid        = 4'(s_rsid);
    eng_accept    = s_acc;
    eng_state_out = SW'($urandom);
    if (s_rst) begin
      m_total = 0;
      m_sat   = 0;
      m_spec  = 0;
      for (int i = 0; i < NS; i++) begin
        m_svld[i] = 0;
        m_pcnt[i] = 0;
      end
      x = '{vld: 0, chk_st: 1, st: 0, total: 0, sat: 0, rd: 0};
    end else begin
      x.vld    = s_ld | s_rs;
      x.chk_st = x.vld;
      if (s_rs) x.st = 0;
      else if (s_e && s_en) x.st = int'(eng_state_out);
      else x.st = m_svld[s_sid] ? m_state[s_sid] : 0;
      x.rd = m_pcnt[s_rsid];
      if (s_e && s_en) begin
        amt = m_spec + int'(s_acc);
        if (!s_clr) begin
          if (m_total + amt > CMAX) begin
            m_total = CMAX;
            m_sat   = 1;
          end else begin
            m_total = m_total + amt;
          end
          m_pcnt[s_sid] = (m_pcnt[s_sid] + amt > CMAX) ? CMAX : m_pcnt[s_sid] + amt;
        end
        m_state[s_sid] = int'(eng_state_out);
        m_svld[s_sid]  = 1;
      end
      if (s_clr) begin
        m_total = 0;
        m_sat   = 0;
        for (int i = 0; i < NS; i++) m_pcnt[i] = 0;
      end
      if (s_ld || s_rs || s_e) m_spec = 0;
      else if (s_acc && m_spec < PMAX) m_spec++;
      x.total = m_total;
      x.sat   = m_sat;
      if (x.vld) ld_q.push_back(x.st);
    end
    exp_q.push_back(x);
    {s_rst, s_ld, s_rs, s_e, s_en, s_clr, s_acc} = '0;
  endtask

  task automatic accepts(input int n);
    for (int i = 0; i < n; i++) begin
      s_acc = 1;
      tick();
    end
  endtask

  always @(posedge clk) begin
    exp_t x;
    #1;
    if (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      check("total_count", int'(total_count), x.total);
      check("total_sat", int'(total_sat), int'(x.sat));
      check("rd_count", int'(rd_count), x.rd);
      check("eng_state_vld", int'(eng_state_vld), int'(x.vld));
      if (x.chk_st && !x.vld) check("eng_state_in_reset", int'(eng_state_in), 0);
    end
    if (eng_state_vld) begin
      if (ld_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_load actual=%0d required=no_strobe", eng_state_in);
      end else begin
        check("eng_state_in", int'(eng_state_in), ld_q.pop_front());
      end
    end
  end

  initial begin
    {s_rst, s_ld, s_rs, s_e, s_en, s_clr, s_acc} = '0;
    s_sid  = 0;
    s_rsid = 0;
    s_rst  = 1; tick();
    s_rst  = 1; tick();

    // Fresh packet on stream 3, five matches, commit.
    s_sid = 3; s_rsid = 3; s_rs = 1; tick();
    accepts(5);
    s_e = 1; s_en = 1; tick();
    tick();
    // Restore stream 3, then a never-written stream.
    s_ld = 1; tick();
    s_sid = 9; s_ld = 1; tick();
    // Discarded packet, then a committed one counting only new matches.
    s_sid = 3; s_rs = 1; tick();
    accepts(4);
    s_e = 1; s_en = 0; tick();
    accepts(2);
    s_e = 1; s_en = 1; tick();
    // Accept on the eop cycle, then eop with same-cycle load (bypass).
    s_sid = 5; s_rsid = 5; s_ld = 1; tick();
    accepts(2);
    s_e = 1; s_en = 1; s_acc = 1; tick();
    accepts(1);
    s_e = 1; s_en = 1; s_ld = 1; tick();
    // eop with reset_state: commit then load 0.
    accepts(2);
    s_e = 1; s_en = 1; s_rs = 1; tick();
    tick();
    // Saturation: spec clamps at PMAX, total clamps at CMAX, then clear.
    s_clr = 1; tick();
    for (int k = 0; k < 5; k++) begin
      accepts(20);
      s_e = 1; s_en = 1; tick();
    end
    tick();
    s_clr = 1; tick();
    // clear_counts with a commit: the counts are lost.
    accepts(3);
    s_e = 1; s_en = 1; s_clr = 1; tick();
    tick();
    // Reset mid-packet, then reload of the committed stream returns 0.
    s_sid = 3; s_rsid = 3;
    accepts(3);
    s_rst = 1; tick();
    s_ld = 1; tick();
    s_e = 1; s_en = 1; tick();
    tick();

    for (int i = 0; i < 3000; i++) begin
      s_sid  = int'($urandom_range(NS - 1));
      s_rsid = int'($urandom_range(NS - 1));
      s_acc  = ($urandom_range(1) == 1);
      s_ld   = ($urandom_range(99) < 12);
      s_rs   = ($urandom_range(99) < 5);
      s_e    = ($urandom_range(99) < 20);
      s_en   = ($urandom_range(99) < 75);
      s_clr  = !s_e && ($urandom_range(99) < 3);
      s_rst  = ($urandom_range(299) == 0);
      tick();
    end
    tick();
    tick();
    repeat (3) @(posedge clk);
    #2;
    check("exp_queue_drained", exp_q.size(), 0);
    check("load_queue_drained", ld_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
